// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state codes,
// grant codes and the DMType access-size encodings carried on m_type.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

    // DMType codes follow the RISC-V load/store funct3 layout.
    localparam logic [2:0] DM_BYTE   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_WORD   = 3'b010;
    localparam logic [2:0] DM_BYTE_U = 3'b100;
    localparam logic [2:0] DM_HALF_U = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Per-access watchdog: counts cycles while enabled and flags the cycle in
// which the count reaches TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;
    logic [7:0] count_next;

    assign count_next = count + 8'd1;
    // Expiry is flagged in the cycle whose increment would land on LIMIT,
    // so an access waits exactly TIMEOUT cycles before being abandoned.
    assign expired    = enable && (count_next == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable && !expired) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory with an
// IDLE -> WAIT -> RESP sequence per access, a watchdog and fetch fairness.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TIMEOUT  = 255,
    parameter int FAIR_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_type,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [2:0]    m_type,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic [1:0]    arb_state
);
    localparam int SW = $clog2(FAIR_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_MAX);

    arb_state_e    state;
    arb_gnt_e      gnt;
    logic [SW-1:0] streak;
    logic          grant_data;
    logic          wd_expired;

    assign arb_state = state;
    assign stall_if  = i_req & ~i_done;
    assign stall_mem = d_req & ~d_done;

    // Data normally wins (it belongs to the older instruction); a fetch that
    // has been passed over FAIR_MAX times in a row gets the next slot.
    assign grant_data = d_req && !((streak == STREAK_MAX) && i_req);

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ARB_IDLE),
        .enable (state == ARB_WAIT),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            gnt     <= GNT_I;
            streak  <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_type  <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (i_req || d_req) begin
                        m_req <= 1'b1;
                        state <= ARB_WAIT;
                        if (grant_data) begin
                            gnt     <= GNT_D;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_type  <= d_type;
                            if (!i_req) begin
                                streak <= '0;
                            end else if (streak != STREAK_MAX) begin
                                streak <= streak + 1'b1;
                            end
                        end else begin
                            gnt     <= GNT_I;
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_type  <= DM_WORD;
                            streak  <= '0;
                        end
                    end
                end
                ARB_WAIT: begin
                    // m_ack takes priority over a watchdog expiry in the same cycle.
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= ARB_RESP;
                        if (gnt == GNT_I) begin
                            i_done  <= 1'b1;
                            i_rdata <= m_rdata;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= m_we ? '0 : m_rdata;
                        end
                    end else if (wd_expired) begin
                        m_req <= 1'b0;
                        state <= ARB_RESP;
                        err   <= 1'b1;
                        if (gnt == GNT_I) begin
                            i_done  <= 1'b1;
                            i_rdata <= '0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= '0;
                        end
                    end
                end
                ARB_RESP: begin
                    m_req <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: begin
                    m_req <= 1'b0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, data-before-fetch,
// fairness, watchdog timeout, ack/timeout race and reset mid-access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_type;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        stall_if;
    logic        stall_mem;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_type;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [1:0]  arb_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(255), .FAIR_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_type(d_type), .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_type(m_type), .m_ack(m_ack), .m_rdata(m_rdata),
        .arb_state(arb_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        bit          exp_d [6];
        int          loads;
        int          hi;
        logic [31:0] exp_addr;

        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_type = '0; m_ack = 1'b0; m_rdata = '0;
        tick(); tick();
        check("rst_state", 32'(arb_state), 32'd0);
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_m_type", 32'(m_type), 32'd0);
        check("rst_dones_err", {29'd0, i_done, d_done, err}, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // 1: lone fetch, ack one cycle after m_req
        i_req = 1'b1; i_addr = 32'h0000_0010;
        #1 check("t1_stall_if_on", 32'(stall_if), 32'd1);
        tick();
        check("t1_m_req", 32'(m_req), 32'd1);
        check("t1_m_addr", m_addr, 32'h10);
        check("t1_m_we", 32'(m_we), 32'd0);
        check("t1_state_wait", 32'(arb_state), 32'd1);
        m_ack = 1'b1; m_rdata = 32'h0000_0013;
        tick();
        m_ack = 1'b0;
        check("t1_i_done", 32'(i_done), 32'd1);
        check("t1_i_rdata", i_rdata, 32'h13);
        check("t1_m_req_drop", 32'(m_req), 32'd0);
        check("t1_stall_if_off", 32'(stall_if), 32'd0);
        i_req = 1'b0;
        tick();
        check("t1_done_pulse", 32'(i_done), 32'd0);
        check("t1_state_idle", 32'(arb_state), 32'd0);

        // 2: simultaneous store and fetch; data first
        i_req = 1'b1; i_addr = 32'h0000_0020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_type = 3'b010;
        tick();
        check("t2_m_addr_d", m_addr, 32'h100);
        check("t2_m_we", 32'(m_we), 32'd1);
        check("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
        check("t2_m_type", 32'(m_type), 32'd2);
        check("t2_stall_mem", 32'(stall_mem), 32'd1);
        m_ack = 1'b1; m_rdata = 32'h5555_5555;
        tick();
        m_ack = 1'b0;
        check("t2_d_done", 32'(d_done), 32'd1);
        check("t2_i_not_done", 32'(i_done), 32'd0);
        check("t2_store_rdata", d_rdata, 32'd0);
        check("t2_stall_mem_off", 32'(stall_mem), 32'd0);
        d_req = 1'b0;
        tick();
        tick();
        check("t2_m_addr_i", m_addr, 32'h20);
        check("t2_m_we_i", 32'(m_we), 32'd0);
        m_ack = 1'b1; m_rdata = 32'h0000_0093;
        tick();
        m_ack = 1'b0;
        check("t2_i_done", 32'(i_done), 32'd1);
        check("t2_i_rdata", i_rdata, 32'h93);
        i_req = 1'b0;
        tick();

        // 3: fairness, expected order D,D,D,D,I,D
        loads = 0;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_type = 3'b010;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_addr = exp_d[k] ? 32'h200 + 32'(4 * loads) : 32'h40;
            check($sformatf("t3_grant%0d_addr", k), m_addr, exp_addr);
            m_ack = 1'b1; m_rdata = 32'h1000 + 32'(k);
            tick();
            m_ack = 1'b0;
            check($sformatf("t3_grant%0d_d_done", k), 32'(d_done), 32'(exp_d[k]));
            check($sformatf("t3_grant%0d_i_done", k), 32'(i_done), 32'(!exp_d[k]));
            check($sformatf("t3_grant%0d_err", k), 32'(err), 32'd0);
            check($sformatf("t3_grant%0d_rdata", k), exp_d[k] ? d_rdata : i_rdata,
                  32'h1000 + 32'(k));
            if (exp_d[k]) begin
                loads++;
                d_addr = 32'h200 + 32'(4 * loads);
            end else begin
                i_addr = 32'h44;
            end
            if (k == 5) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            tick();
        end

        // 4: load with no ack, watchdog aborts after 255 WAIT cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        hi = 0;
        while (m_req && hi < 400) begin
            hi++;
            tick();
        end
        check("t4_wait_cycles", 32'(hi), 32'd255);
        check("t4_d_done", 32'(d_done), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        tick();
        m_ack = 1'b0;
        check("t4_late_ack_done", {30'd0, d_done, err}, 32'd0);
        check("t4_late_ack_rdata", d_rdata, 32'd0);
        check("t4_late_ack_state", 32'(arb_state), 32'd0);

        // 5: ack lands in the expiry cycle (255th WAIT cycle)
        d_req = 1'b1; d_addr = 32'h304;
        tick();
        repeat (254) tick();
        check("t5_still_waiting", 32'(m_req), 32'd1);
        m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick();
        m_ack = 1'b0;
        check("t5_d_done", 32'(d_done), 32'd1);
        check("t5_err", 32'(err), 32'd0);
        check("t5_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        tick();

        // 6: reset while waiting, then a fresh fetch
        i_req = 1'b1; i_addr = 32'h80;
        tick();
        check("t6_m_req_wait", 32'(m_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_m_req", 32'(m_req), 32'd0);
        check("t6_rst_no_done", {30'd0, i_done, d_done}, 32'd0);
        check("t6_rst_state", 32'(arb_state), 32'd0);
        check("t6_rst_m_addr", m_addr, 32'd0);
        check("t6_rst_rdata", i_rdata | d_rdata, 32'd0);
        tick();
        check("t6_reissue_addr", m_addr, 32'h80);
        check("t6_reissue_req", 32'(m_req), 32'd1);
        m_ack = 1'b1; m_rdata = 32'h0000_1234;
        tick();
        m_ack = 1'b0;
        check("t6_i_done", 32'(i_done), 32'd1);
        check("t6_i_rdata", i_rdata, 32'h1234);
        i_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
